// File: rtl/fetch_master.sv
// Avalon-MM read master that prefetches sequential words into a small FIFO.
// One read outstanding at most; start_valid restarts the stream at a new address.
module fetch_master #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] ADDR_STEP = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_valid,
  input  logic [31:0] start_addr,
  output logic [31:0] av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  input  logic        av_readdatavalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          running, discard, load_req;
  logic          accept, rsp, push, pop;
  logic [31:0]   fetch_addr;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] fifo_count, count_nxt;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   head_nxt;

  assign av_read    = (state == REQ);
  assign busy       = (state == REQ) || (state == WAIT_DATA);
  assign accept     = av_read && !av_waitrequest;
  assign rsp        = (state == WAIT_DATA) && av_readdatavalid;
  assign push       = rsp && !discard && !start_valid;
  assign pop        = out_valid && out_ready;
  assign rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign count_nxt  = start_valid ? '0 : fifo_count + CW'(push) - CW'(pop);

  // Issue decisions use the post-push/pop count, and with nothing outstanding
  // at that point the slot rule reduces to count_nxt < DEPTH.
  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid || (running && count_nxt < DEPTH_C)) begin
          state_nxt = REQ;
          load_req  = 1'b1;
        end
      end
      REQ: begin
        if (accept) state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (rsp) begin
          if (count_nxt < DEPTH_C) begin
            state_nxt = REQ;
            load_req  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      running    <= 1'b0;
      discard    <= 1'b0;
      fetch_addr <= '0;
      av_address <= '0;
    end else begin
      state <= state_nxt;
      if (start_valid) running <= 1'b1;
      if (load_req) av_address <= start_valid ? start_addr : fetch_addr;
      // A read already in flight at restart must not advance the new stream.
      if (start_valid) fetch_addr <= start_addr;
      else if (accept && !discard) fetch_addr <= fetch_addr + ADDR_STEP;
      if (start_valid && ((state == REQ) || ((state == WAIT_DATA) && !av_readdatavalid)))
        discard <= 1'b1;
      else if (rsp)
        discard <= 1'b0;
    end
  end

  // Head register is refilled from storage, or bypassed from the incoming word
  // when no older entry remains after this cycle's pop.
  always_comb begin
    if ((fifo_count - CW'(pop)) == '0) head_nxt = {av_readdata, av_address};
    else                               head_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {av_readdata, av_address};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
    end else if (start_valid) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
      out_valid  <= (count_nxt != '0);
      if (count_nxt != '0) {out_data, out_addr} <= head_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_master.sv
// Directed bench for fetch_master: behavioural Avalon slave with configurable
// latency/waitrequest, a negedge monitor, and one task per scenario.
module tb_fetch_master;

  localparam logic [31:0] DMASK = 32'hDA7A0000;

  logic        clk, rst, start_valid, out_ready, out_valid, busy;
  logic        av_read, av_waitrequest, av_readdatavalid;
  logic [31:0] start_addr, av_address, av_readdata, out_data, out_addr;

  int          n_vec, n_err;
  int          lat_cfg, wait_cfg;
  logic        stray;
  logic [31:0] acc_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] got_addr[$];

  logic        pend;
  int          cnt, wr_cnt;
  logic [31:0] paddr;

  fetch_master #(.DEPTH(4), .ADDR_STEP(32'd1)) dut (
    .clk(clk), .reset(rst), .start_valid(start_valid), .start_addr(start_addr),
    .av_address(av_address), .av_read(av_read), .av_waitrequest(av_waitrequest),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave: returns addr ^ DMASK lat_cfg cycles after acceptance.
  initial begin
    av_waitrequest = 1'b0; av_readdatavalid = 1'b0; av_readdata = '0;
    pend = 1'b0; cnt = 0; wr_cnt = 0; paddr = '0;
    forever begin
      @(negedge clk); #1;
      av_readdatavalid = 1'b0;
      if (rst) begin
        pend = 1'b0; wr_cnt = 0; av_waitrequest = 1'b0;
      end else begin
        if (stray) begin
          av_readdatavalid = 1'b1; av_readdata = 32'hBADBAD00;
        end else if (pend) begin
          if (cnt <= 1) begin
            av_readdatavalid = 1'b1; av_readdata = paddr ^ DMASK; pend = 1'b0;
          end else cnt--;
        end
        if (av_read && !pend) begin
          if (wr_cnt < wait_cfg) begin
            av_waitrequest = 1'b1; wr_cnt++;
          end else begin
            av_waitrequest = 1'b0; wr_cnt = 0; pend = 1'b1; paddr = av_address; cnt = lat_cfg;
          end
        end else av_waitrequest = 1'b0;
      end
    end
  end

  // Monitor: records command acceptances and consumer handshakes due at the next edge.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        if (av_read && !av_waitrequest) acc_addr.push_back(av_address);
        if (out_valid && out_ready) begin
          got_data.push_back(out_data);
          got_addr.push_back(out_addr);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start_valid = 1'b0; out_ready = 1'b0; wait_cfg = 0; stray = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; start_addr = '0; out_ready = 1'b0;
    stray = 1'b0; wait_cfg = 0; lat_cfg = 1;
    step(2);
    n_vec++; if (av_read !== 1'b0) begin n_err++; $display("FAIL reset_av_read: got %b want 0", av_read); end
    n_vec++; if (av_address !== 32'h0) begin n_err++; $display("FAIL reset_av_address: got %h want 0", av_address); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_vec++; if (out_addr !== 32'h0) begin n_err++; $display("FAIL reset_out_addr: got %h want 0", out_addr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_stream();
    int gb;
    do_reset();
    lat_cfg = 12; out_ready = 1'b1; gb = got_addr.size();
    start_valid = 1'b1; start_addr = 32'h10;
    step(1);
    start_valid = 1'b0;
    n_vec++; if (av_read !== 1'b1) begin n_err++; $display("FAIL stream_first_read: got %b want 1", av_read); end
    n_vec++; if (av_address !== 32'h10) begin n_err++; $display("FAIL stream_first_addr: got %h want 00000010", av_address); end
    for (int i = 0; i < 150 && got_addr.size() < gb + 3; i++) step(1);
    n_vec++; if (got_addr.size() < gb + 3) begin n_err++; $display("FAIL stream_timeout: got %0d words want 3", got_addr.size() - gb); end
    n_vec++; if (got_addr[gb] !== 32'h10 || got_data[gb] !== 32'hDA7A0010) begin n_err++; $display("FAIL stream_w0: got %h/%h want 00000010/da7a0010", got_addr[gb], got_data[gb]); end
    n_vec++; if (got_addr[gb+1] !== 32'h11 || got_data[gb+1] !== 32'hDA7A0011) begin n_err++; $display("FAIL stream_w1: got %h/%h want 00000011/da7a0011", got_addr[gb+1], got_data[gb+1]); end
    n_vec++; if (got_addr[gb+2] !== 32'h12 || got_data[gb+2] !== 32'hDA7A0012) begin n_err++; $display("FAIL stream_w2: got %h/%h want 00000012/da7a0012", got_addr[gb+2], got_data[gb+2]); end
  endtask

  task automatic test_full();
    int ab, gb;
    do_reset();
    lat_cfg = 2; out_ready = 1'b0; ab = acc_addr.size(); gb = got_addr.size();
    start_valid = 1'b1; start_addr = 32'h100;
    step(1);
    start_valid = 1'b0;
    step(40);
    n_vec++; if (acc_addr.size() - ab != 4) begin n_err++; $display("FAIL full_reads: got %0d want 4", acc_addr.size() - ab); end
    n_vec++; if (av_read !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL full_idle: got av_read=%b busy=%b want 0/0", av_read, busy); end
    n_vec++; if (out_valid !== 1'b1 || out_addr !== 32'h100) begin n_err++; $display("FAIL full_head: got %b/%h want 1/00000100", out_valid, out_addr); end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(20);
    n_vec++; if (acc_addr.size() - ab != 5) begin n_err++; $display("FAIL full_refill_reads: got %0d want 5", acc_addr.size() - ab); end
    n_vec++; if (acc_addr[ab+4] !== 32'h104) begin n_err++; $display("FAIL full_refill_addr: got %h want 00000104", acc_addr[ab+4]); end
    n_vec++; if (got_addr.size() - gb != 1 || got_addr[gb] !== 32'h100) begin n_err++; $display("FAIL full_pop: got %0d/%h want 1/00000100", got_addr.size() - gb, got_addr[gb]); end
    n_vec++; if (out_addr !== 32'h101 || out_data !== 32'hDA7A0101) begin n_err++; $display("FAIL full_next_head: got %h/%h want 00000101/da7a0101", out_addr, out_data); end
  endtask

  task automatic test_wait();
    int ab, gb;
    do_reset();
    lat_cfg = 3; wait_cfg = 5; out_ready = 1'b1; ab = acc_addr.size(); gb = got_addr.size();
    start_valid = 1'b1; start_addr = 32'h20;
    step(1);
    start_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (av_read !== 1'b1 || av_address !== 32'h20) begin n_err++; $display("FAIL wait_hold_%0d: got %b/%h want 1/00000020", k, av_read, av_address); end
      step(1);
    end
    wait_cfg = 0;
    step(1);
    n_vec++; if (acc_addr.size() - ab != 1 || av_read !== 1'b0) begin n_err++; $display("FAIL wait_accept: got %0d/%b want 1/0", acc_addr.size() - ab, av_read); end
    for (int i = 0; i < 60 && got_addr.size() < gb + 2; i++) step(1);
    n_vec++; if (got_addr[gb] !== 32'h20 || got_data[gb] !== 32'hDA7A0020) begin n_err++; $display("FAIL wait_word: got %h/%h want 00000020/da7a0020", got_addr[gb], got_data[gb]); end
    n_vec++; if (got_addr[gb+1] !== 32'h21) begin n_err++; $display("FAIL wait_single_push: got %h want 00000021", got_addr[gb+1]); end
  endtask

  task automatic test_flush();
    int ab, gb;
    do_reset();
    lat_cfg = 6; out_ready = 1'b0; ab = acc_addr.size(); gb = got_addr.size();
    start_valid = 1'b1; start_addr = 32'h10;
    step(1);
    start_valid = 1'b0;
    for (int i = 0; i < 100 && !(acc_addr.size() - ab == 3 && av_read === 1'b0); i++) step(1);
    n_vec++; if (acc_addr.size() - ab != 3 || acc_addr[ab+2] !== 32'h12) begin n_err++; $display("FAIL flush_setup: got %0d reads last %h want 3/00000012", acc_addr.size() - ab, acc_addr[ab+2]); end
    start_valid = 1'b1; start_addr = 32'h40;
    step(1);
    start_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b want 0", out_valid); end
    n_vec++; if (av_read !== 1'b0) begin n_err++; $display("FAIL flush_no_issue: got %b want 0", av_read); end
    for (int i = 0; i < 60 && acc_addr.size() - ab < 4; i++) step(1);
    n_vec++; if (acc_addr[ab+3] !== 32'h40) begin n_err++; $display("FAIL flush_restart_addr: got %h want 00000040", acc_addr[ab+3]); end
    out_ready = 1'b1;
    for (int i = 0; i < 60 && got_addr.size() < gb + 1; i++) step(1);
    n_vec++; if (got_addr[gb] !== 32'h40 || got_data[gb] !== 32'hDA7A0040) begin n_err++; $display("FAIL flush_first_out: got %h/%h want 00000040/da7a0040", got_addr[gb], got_data[gb]); end
  endtask

  task automatic test_wrap();
    int ab, gb;
    do_reset();
    lat_cfg = 1; out_ready = 1'b1; ab = acc_addr.size(); gb = got_addr.size();
    start_valid = 1'b1; start_addr = 32'hFFFFFFFF;
    step(1);
    start_valid = 1'b0;
    for (int i = 0; i < 40 && got_addr.size() < gb + 2; i++) step(1);
    n_vec++; if (acc_addr[ab] !== 32'hFFFFFFFF || acc_addr[ab+1] !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h,%h want ffffffff,00000000", acc_addr[ab], acc_addr[ab+1]); end
    n_vec++; if (got_data[gb] !== 32'h2585FFFF || got_addr[gb+1] !== 32'h0) begin n_err++; $display("FAIL wrap_data: got %h/%h want 2585ffff/00000000", got_data[gb], got_addr[gb+1]); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    lat_cfg = 2; out_ready = 1'b0;
    start_valid = 1'b1; start_addr = 32'h80;
    step(1);
    start_valid = 1'b0;
    for (int i = 0; i < 50 && out_valid !== 1'b1; i++) step(1);
    wait_cfg = 20;
    step(2);
    n_vec++; if (av_read !== 1'b1 || av_address !== 32'h81 || out_valid !== 1'b1) begin n_err++; $display("FAIL abort_setup: got %b/%h/%b want 1/00000081/1", av_read, av_address, out_valid); end
    rst = 1'b1;
    #1;
    n_vec++; if (av_read !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL abort_immediate: got av_read=%b out_valid=%b want 0/0", av_read, out_valid); end
    n_vec++; if (busy !== 1'b0 || av_address !== 32'h0) begin n_err++; $display("FAIL abort_state: got busy=%b addr=%h want 0/00000000", busy, av_address); end
    step(1);
    rst = 1'b0; wait_cfg = 0; stray = 1'b1;
    step(1);
    stray = 1'b0;
    step(3);
    n_vec++; if (out_valid !== 1'b0 || av_read !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_stray: got %b/%b/%b want 0/0/0", out_valid, av_read, busy); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_stream();
    test_full();
    test_wait();
    test_flush();
    test_wrap();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
